uart_tx_mmio: RTL and testbench

Memory-mapped UART transmitter on the CPU data bus, beside the data RAM. It decodes CPU stores and loads within a small address window. Bytes written to TXDATA are queued in a FIFO and serialised 8N1, LSB first, on `tx`. A STATUS register lets firmware poll for space or completion; the top level muxes `read_data` into the CPU `load_data` path when `sel` is high.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_tx_mmio_if.sv | 21 ++
 rtl/uart_tx_mmio_sync_fifo.sv | 52 +++++
 rtl/uart_tx_mmio.sv | 158 +++++++++++++++
 tb/tb_uart_tx_mmio.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam logic [2:0] OFF_TXDATA = 3'd0;
    localparam logic [2:0] OFF_STATUS = 3'd4;

    localparam int ST_FULL      = 0;
    localparam int ST_EMPTY     = 1;
    localparam int ST_ACTIVE    = 2;
    localparam int ST_OVERFLOW  = 3;
    localparam int ST_COUNT_LSB = 4;

    // STATUS only has a 4-bit count field, so deeper FIFOs report 15.
    function automatic logic [3:0] sat_count(input logic [31:0] count);
        return (count > 32'd15) ? 4'hF : count[3:0];
    endfunction

endpackage

// File: rtl/uart_tx_mmio_if.sv
// CPU data-bus view of the UART register window.
interface uart_tx_mmio_if;

    logic [31:0] address;
    logic        store;
    logic [31:0] store_data;
    logic        load;
    logic        sel;
    logic [31:0] read_data;

    modport master (
        output address, store, store_data, load,
        input  sel, read_data
    );

    modport slave (
        input  address, store, store_data, load,
        output sel, read_data
    );

endinterface

// File: rtl/uart_tx_mmio_sync_fifo.sv
// Synchronous FIFO with occupancy count; a push alongside a pop is accepted when full.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == FULL_COUNT);
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS registers, TX FIFO and serialiser.
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    uart_tx_mmio_if.slave        bus,
    output logic                 tx,
    output logic                 busy
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    logic          sel;
    logic [2:0]    reg_off;
    logic          wr_txdata;
    logic          wr_status;
    logic          overflow;
    logic [31:0]   status;

    logic          fifo_pop;
    logic [7:0]    fifo_head;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    tx_state_t     state, state_next;
    logic [BW-1:0] baud_cnt, baud_next;
    logic [2:0]    bit_cnt, bit_next;
    logic [7:0]    shift, shift_next;
    logic          baud_done;

    logic          unused_bus;
    assign unused_bus = ^{bus.address[1:0], bus.store_data[31:8], bus.load};

    assign sel       = (bus.address[31:3] == BASE_ADDR[31:3]);
    assign reg_off   = {bus.address[2], 2'b00};
    assign wr_txdata = bus.store && sel && (reg_off == OFF_TXDATA);
    assign wr_status = bus.store && sel && (reg_off == OFF_STATUS);
    assign bus.sel   = sel;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (wr_txdata),
        .push_data (bus.store_data[7:0]),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // A push that lands on a full FIFO is only lost if the serialiser is not popping that cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (wr_status && bus.store_data[ST_OVERFLOW]) begin
            overflow <= 1'b0;
        end else if (wr_txdata && fifo_full && !fifo_pop) begin
            overflow <= 1'b1;
        end
    end

    always_comb begin
        status                        = '0;
        status[ST_FULL]               = fifo_full;
        status[ST_EMPTY]              = fifo_empty;
        status[ST_ACTIVE]             = (state != IDLE);
        status[ST_OVERFLOW]           = overflow;
        status[ST_COUNT_LSB +: 4]     = sat_count(32'(fifo_count));
        bus.read_data                 = (sel && reg_off == OFF_STATUS) ? status : '0;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_cnt  <= bit_next;
            shift    <= shift_next;
        end
    end

    assign baud_done = (baud_cnt == BAUD_LAST);

    // STOP chains straight into the next START when data is waiting, so frames abut.
    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        bit_next   = bit_cnt;
        shift_next = shift;
        fifo_pop   = 1'b0;
        tx         = 1'b1;
        case (state)
            IDLE: begin
                baud_next = '0;
                if (!fifo_empty) begin
                    state_next = START;
                    fifo_pop   = 1'b1;
                    shift_next = fifo_head;
                end
            end
            START: begin
                tx = 1'b0;
                if (baud_done) begin
                    baud_next  = '0;
                    bit_next   = '0;
                    state_next = DATA;
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                tx = shift[0];
                if (baud_done) begin
                    baud_next  = '0;
                    shift_next = {1'b0, shift[7:1]};
                    bit_next   = bit_cnt + 1'b1;
                    if (bit_cnt == 3'd7) state_next = STOP;
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_next = '0;
                    if (!fifo_empty) begin
                        state_next = START;
                        fifo_pop   = 1'b1;
                        shift_next = fifo_head;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench: decode table, hand-written frame sequences and randomised traffic vs a frame-timing model.
module tb_uart_tx_mmio;

    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int          CPB   = 4;
    localparam int          DEPTH = 4;
    localparam int          FRAME = 10 * CPB;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic tx;
    logic busy;

    uart_tx_mmio_if bus();

    uart_tx_mmio #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .tx    (tx),
        .busy  (busy)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Reference model: queued bytes plus cycles left in the frame on the wire.
    logic [7:0] q[$];
    int         rem = 0;
    logic       ovf = 1'b0;
    logic [7:0] cur = 8'h00;

    logic        last_sel;
    logic [31:0] last_rd;
    logic        last_tx;
    logic        last_busy;

    typedef struct {
        string       name;
        logic        st;
        logic [31:0] addr;
        logic [31:0] data;
        logic        exp_sel;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[11];

    function automatic logic [31:0] model_status();
        int n;
        logic [3:0] c;
        n = q.size();
        c = (n > 15) ? 4'd15 : 4'(n);
        return {24'h0, c, ovf, (rem > 0), (n == 0), (n == DEPTH)};
    endfunction

    function automatic logic model_sel(input logic [31:0] addr);
        return (addr[31:3] == BASE[31:3]);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        if (!model_sel(addr)) return 32'h0;
        return addr[2] ? model_status() : 32'h0;
    endfunction

    // Wire level from position in the frame: start slot, 8 data slots, stop slot.
    function automatic logic model_tx();
        int pos;
        int slot;
        if (rem == 0) return 1'b1;
        pos  = FRAME - rem;
        slot = pos / CPB;
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        return cur[slot-1];
    endfunction

    task automatic model_edge(input logic st, input logic [31:0] addr, input logic [31:0] data);
        logic do_pop;
        logic push;
        logic accept;
        if (!reset) begin
            q.delete();
            rem = 0;
            ovf = 1'b0;
        end else begin
            do_pop = (q.size() > 0) && (rem <= 1);
            push   = st && model_sel(addr) && !addr[2];
            accept = push && ((q.size() < DEPTH) || do_pop);
            if (push && !accept) ovf = 1'b1;
            if (st && model_sel(addr) && addr[2] && data[3]) ovf = 1'b0;
            if (do_pop) begin
                cur = q.pop_front();
                rem = FRAME;
            end else if (rem > 0) begin
                rem = rem - 1;
            end
            if (accept) q.push_back(data[7:0]);
        end
    endtask

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic st, input logic [31:0] addr, input logic [31:0] data);
        bus.address    = addr;
        bus.store      = st;
        bus.store_data = data;
        bus.load       = !st;
        #1;
        last_sel = bus.sel;
        last_rd  = bus.read_data;
        check_output("sel", {31'h0, last_sel}, {31'h0, model_sel(addr)});
        check_output("read_data", last_rd, model_read(addr));
        @(posedge clock);
        model_edge(st, addr, data);
        #1;
        last_tx   = tx;
        last_busy = busy;
        check_output("tx", {31'h0, last_tx}, {31'h0, model_tx()});
        check_output("busy", {31'h0, last_busy}, {31'h0, ((rem > 0) || (q.size() > 0))});
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((rem != 0 || q.size() != 0) && n < 500) begin
            apply_stimulus(1'b0, BASE + 32'd4, 32'h0);
            n++;
        end
        if (n >= 500) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain_timeout actual=%0d cycles required=idle", n);
        end
    endtask

    initial begin
        logic slot_vals[10];
        logic [31:0] addr;
        int quiet;

        bus.address    = 32'h0;
        bus.store      = 1'b0;
        bus.store_data = 32'h0;
        bus.load       = 1'b0;

        vecs[0]  = '{"txdata_rd",    1'b0, BASE,               32'h0,  1'b1, 32'h0};
        vecs[1]  = '{"status_rd",    1'b0, BASE + 32'd4,       32'h0,  1'b1, 32'h2};
        vecs[2]  = '{"status_b6",    1'b0, BASE + 32'd6,       32'h0,  1'b1, 32'h2};
        vecs[3]  = '{"txdata_b3",    1'b0, BASE + 32'd3,       32'h0,  1'b1, 32'h0};
        vecs[4]  = '{"above_rd",     1'b0, BASE + 32'd8,       32'h0,  1'b0, 32'h0};
        vecs[5]  = '{"below_rd",     1'b0, BASE - 32'd4,       32'h0,  1'b0, 32'h0};
        vecs[6]  = '{"above_wr",     1'b1, BASE + 32'd8,       32'h55, 1'b0, 32'h0};
        vecs[7]  = '{"below_wr",     1'b1, BASE - 32'd4,       32'h55, 1'b0, 32'h0};
        vecs[8]  = '{"status_wr",    1'b1, BASE + 32'd4,       32'h8,  1'b1, 32'h2};
        vecs[9]  = '{"far_rd",       1'b0, 32'h1000_0010,      32'h0,  1'b0, 32'h0};
        vecs[10] = '{"alias_rd",     1'b0, 32'h9000_0004,      32'h0,  1'b0, 32'h0};

        // Reset held for two cycles.
        reset = 1'b0;
        apply_stimulus(1'b0, 32'h0, 32'h0);
        apply_stimulus(1'b0, 32'h0, 32'h0);
        reset = 1'b1;
        check_output("reset_tx", {31'h0, last_tx}, 32'h1);
        check_output("reset_busy", {31'h0, last_busy}, 32'h0);
        apply_stimulus(1'b0, BASE + 32'd4, 32'h0);
        check_output("reset_status", last_rd, 32'h2);

        // Address decode table from idle.
        for (int i = 0; i < 11; i++) begin
            apply_stimulus(vecs[i].st, vecs[i].addr, vecs[i].data);
            check_output({vecs[i].name, "_sel"}, {31'h0, last_sel}, {31'h0, vecs[i].exp_sel});
            check_output({vecs[i].name, "_rd"}, last_rd, vecs[i].exp_rd);
        end
        apply_stimulus(1'b0, BASE + 32'd4, 32'h0);
        check_output("decode_fifo_unchanged", last_rd, 32'h2);
        check_output("decode_busy", {31'h0, last_busy}, 32'h0);

        // Single 0xA5 frame against a hand-written waveform.
        slot_vals = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        drain();
        apply_stimulus(1'b1, BASE, 32'hA5);
        check_output("a5_tx_after_store", {31'h0, last_tx}, 32'h1);
        check_output("a5_busy_after_store", {31'h0, last_busy}, 32'h1);
        for (int i = 0; i < FRAME; i++) begin
            apply_stimulus(1'b0, BASE + 32'd4, 32'h0);
            check_output($sformatf("a5_wave_%0d", i), {31'h0, last_tx}, {31'h0, slot_vals[i / CPB]});
        end
        check_output("a5_busy_last_stop", {31'h0, last_busy}, 32'h1);
        apply_stimulus(1'b0, BASE + 32'd4, 32'h0);
        check_output("a5_busy_fall", {31'h0, last_busy}, 32'h0);
        check_output("a5_tx_idle", {31'h0, last_tx}, 32'h1);

        // Five back-to-back bytes fit, six more overflow, then overflow is cleared.
        for (int i = 0; i < 5; i++) apply_stimulus(1'b1, BASE, 32'(8'h30 + i));
        apply_stimulus(1'b0, BASE + 32'd4, 32'h0);
        check_output("b2b_status_no_ovf", last_rd, 32'h45);
        for (int i = 0; i < 6; i++) apply_stimulus(1'b1, BASE, 32'(8'h60 + i));
        apply_stimulus(1'b0, BASE + 32'd4, 32'h0);
        check_output("b2b_status_ovf", last_rd, 32'h4D);
        apply_stimulus(1'b1, BASE + 32'd4, 32'h8);
        apply_stimulus(1'b0, BASE + 32'd4, 32'h0);
        check_output("ovf_clear_status", last_rd, 32'h45);
        drain();

        // Reset in the middle of a data bit with three bytes queued.
        for (int i = 0; i < 4; i++) apply_stimulus(1'b1, BASE, 32'(8'hC0 + i));
        for (int i = 0; i < 10; i++) apply_stimulus(1'b0, BASE + 32'd4, 32'h0);
        reset = 1'b0;
        apply_stimulus(1'b0, BASE + 32'd4, 32'h0);
        reset = 1'b1;
        check_output("midreset_tx", {31'h0, last_tx}, 32'h1);
        apply_stimulus(1'b0, BASE + 32'd4, 32'h0);
        check_output("midreset_status", last_rd, 32'h2);
        quiet = 0;
        for (int i = 0; i < 60; i++) begin
            apply_stimulus(1'b0, BASE + 32'd4, 32'h0);
            if (last_tx !== 1'b1) quiet++;
        end
        check_output("midreset_no_frames", quiet, 0);
        check_output("midreset_busy", {31'h0, last_busy}, 32'h0);

        // Randomised traffic: sparse, then dense with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(5))
                0:       addr = BASE;
                1:       addr = BASE + 32'd4;
                2:       addr = BASE + 32'($urandom_range(7));
                3:       addr = BASE + 32'd8;
                4:       addr = BASE - 32'd4;
                default: addr = $urandom;
            endcase
            reset = ($urandom_range(199) != 0);
            apply_stimulus(($urandom_range(99) < ((i < 1000) ? 8 : 40)), addr, $urandom);
        end
        reset = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
